// File: rtl/ola_trigger_sequencer.sv
// ola_trigger_sequencer: loads trigger stage masks serially and walks the armed stage chain to fire capture.
// Optional stage timeout enabled by defining OLA_TRIGGER_SEQ_TIMEOUT_EN.
module ola_trigger_sequencer #(
    parameter int STATE_COUNT     = 4,
    parameter int STATE_BITS      = 2,
    parameter int CONDITION_WIDTH = 4,
    parameter int ACTION_WIDTH    = 4,
    parameter int CFG_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [STATE_BITS-1:0]                cfg_state,
    input  logic                                 cfg_else,
    input  logic                                 cfg_kind,
    input  logic [CFG_WIDTH-1:0]                 cfg_word,
    input  logic                                 arm,
    input  logic                                 disarm,
    output logic [STATE_COUNT-1:0]               ctl_enable,
    output logic                                 ctl_data,
    output logic                                 ctl_then,
    output logic                                 ctl_else,
    output logic                                 ctl_conditions,
    output logic                                 ctl_actions,
    input  logic [STATE_COUNT-1:0]               st_act,
    input  logic [STATE_COUNT*ACTION_WIDTH-1:0]  st_actions,
    output logic [STATE_BITS-1:0]                cur_state,
    output logic                                 armed,
    output logic                                 fire,
    output logic [ACTION_WIDTH-1:0]              fire_actions,
    output logic                                 timeout
);
    localparam int BW = $clog2(CFG_WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, ARMED} state_t;

    state_t                  r_state, w_state;
    logic [STATE_BITS-1:0]   r_sel, w_sel;
    logic                    r_else, w_else;
    logic                    r_kind, w_kind;
    logic [CFG_WIDTH-1:0]    r_word, w_word;
    logic [BW-1:0]           r_bit, w_bit;
    logic [STATE_BITS-1:0]   w_cur;
    logic                    w_fire;
    logic [ACTION_WIDTH-1:0] w_fire_actions;
    logic                    w_timeout;
    logic                    w_act;
    logic [ACTION_WIDTH-1:0] w_acts;
    logic                    w_last;
    logic                    w_shift;
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]           r_tmo, w_tmo;
`endif

    always_comb begin
        w_state        = r_state;
        w_sel          = r_sel;
        w_else         = r_else;
        w_kind         = r_kind;
        w_word         = r_word;
        w_bit          = r_bit;
        w_cur          = cur_state;
        w_fire         = 1'b0;
        w_fire_actions = fire_actions;
        w_timeout      = 1'b0;
        w_act          = st_act[cur_state];
        w_acts         = st_actions[cur_state*ACTION_WIDTH +: ACTION_WIDTH];
        w_last         = r_bit == (r_kind ? BW'(ACTION_WIDTH - 1) : BW'(CONDITION_WIDTH - 1));
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
        w_tmo          = r_tmo;
`endif
        case (r_state)
            IDLE: begin
                if (cfg_valid) begin
                    w_sel   = cfg_state;
                    w_else  = cfg_else;
                    w_kind  = cfg_kind;
                    w_word  = cfg_word;
                    w_bit   = '0;
                    w_state = SHIFT;
                end else if (arm) begin
                    w_cur   = '0;
                    w_state = ARMED;
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
                    w_tmo   = '0;
`endif
                end
            end
            SHIFT: begin
                w_bit   = r_bit + 1'b1;
                w_state = w_last ? GAP : SHIFT;
            end
            GAP: w_state = IDLE;
            ARMED: begin
                if (disarm) begin
                    w_state = IDLE;
                end else begin
                    if (w_act) begin
                        w_fire         = w_acts[0];
                        w_fire_actions = w_acts[0] ? w_acts : fire_actions;
                        w_cur          = w_acts[2] ? '0 :
                                         w_acts[1] ? ((cur_state == STATE_BITS'(STATE_COUNT - 1)) ? '0 : cur_state + 1'b1) :
                                         cur_state;
                    end
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
                    // any act or sitting at stage 0 keeps the idle counter cleared
                    w_tmo = (w_act || cur_state == '0) ? '0 : r_tmo + 1'b1;
                    if (!w_act && cur_state != '0 && r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        w_cur     = '0;
                        w_timeout = 1'b1;
                        w_tmo     = '0;
                    end
`endif
                    if (arm) begin
                        w_cur = '0;
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
                        w_tmo = '0;
`endif
                    end
                end
            end
            default: w_state = IDLE;
        endcase
        w_shift = w_state == SHIFT;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_sel          <= '0;
            r_else         <= 1'b0;
            r_kind         <= 1'b0;
            r_word         <= '0;
            r_bit          <= '0;
            cfg_ready      <= 1'b1;
            ctl_enable     <= '0;
            ctl_data       <= 1'b0;
            ctl_then       <= 1'b0;
            ctl_else       <= 1'b0;
            ctl_conditions <= 1'b0;
            ctl_actions    <= 1'b0;
            cur_state      <= '0;
            armed          <= 1'b0;
            fire           <= 1'b0;
            fire_actions   <= '0;
            timeout        <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_sel          <= w_sel;
            r_else         <= w_else;
            r_kind         <= w_kind;
            r_word         <= w_word;
            r_bit          <= w_bit;
            cfg_ready      <= w_state == IDLE;
            ctl_enable     <= w_shift ? STATE_COUNT'(1) << w_sel : '0;
            ctl_data       <= w_shift && w_word[w_bit];
            ctl_then       <= w_shift && !w_else;
            ctl_else       <= w_shift && w_else;
            ctl_conditions <= w_shift && !w_kind;
            ctl_actions    <= w_shift && w_kind;
            cur_state      <= w_cur;
            armed          <= w_state == ARMED;
            fire           <= w_fire;
            fire_actions   <= w_fire_actions;
            timeout        <= w_timeout;
        end
    end

`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_tmo <= '0;
        else       r_tmo <= w_tmo;
    end
`endif
endmodule

// File: doc/ola_trigger_sequencer.md
# ola_trigger_sequencer

Controller for a bank of `ola_trigger_state` stages that together form a multi-stage trigger.
- Loads each stage's then/else condition and action masks over that stage's serial control interface, from parallel host words.
- While armed, tracks the current stage, samples that stage's act/actions outputs, and advances, restarts or fires the capture trigger.
- Sits between the host register interface and the capture controller.

## Interface
Parameters:
- `STATE_COUNT`, 4, number of trigger stages (≥2).
- `STATE_BITS`, 2, width of stage index; `2**STATE_BITS >= STATE_COUNT`.
- `CONDITION_WIDTH`, 4, condition mask width of each stage.
- `ACTION_WIDTH`, 4, action word width of each stage (≥3).
- `CFG_WIDTH`, 16, host word width; must be ≥ max(`CONDITION_WIDTH`, `ACTION_WIDTH`).
- `TIMEOUT_CYCLES`, 1024, stage timeout; used only with the macro.

Ports:
- `clock`, in, 1, clock.
- `reset`, in, 1, asynchronous active-high reset.
- `cfg_valid`, in, 1, host config word valid.
- `cfg_ready`, out, 1, sequencer accepts a config word.
- `cfg_state`, in, `STATE_BITS`, target stage.
- `cfg_else`, in, 1, 0 = then branch, 1 = else branch.
- `cfg_kind`, in, 1, 0 = conditions, 1 = actions.
- `cfg_word`, in, `CFG_WIDTH`, mask value; low bits used.
- `arm`, in, 1, start trigger sequencing.
- `disarm`, in, 1, stop sequencing.
- `ctl_enable`, out, `STATE_COUNT`, one-hot stage shift enable.
- `ctl_data`, `ctl_then`, `ctl_else`, `ctl_conditions`, `ctl_actions`, out, 1 each, shared stage control.
- `st_act`, in, `STATE_COUNT`, per-stage act (combinatorial from stages).
- `st_actions`, in, `STATE_COUNT*ACTION_WIDTH`, per-stage actions; stage k at bits [k*AW +: AW].
- `cur_state`, out, `STATE_BITS`, current stage index.
- `armed`, out, 1, sequencer in ARMED state.
- `fire`, out, 1, one-cycle capture trigger pulse.
- `fire_actions`, out, `ACTION_WIDTH`, action word of last acting stage.
- `timeout`, out, 1, timeout pulse; tied 0 without macro.

## Operation
- FSM states: IDLE, SHIFT, GAP, ARMED.
- `cfg_ready` = 1 only in IDLE.

IDLE:
- `cfg_valid && cfg_ready`: latch state/branch/kind/word, set shift length L (`CONDITION_WIDTH` if kind=0, else `ACTION_WIDTH`), bit counter = 0, go to SHIFT.
- `arm` (with no cfg accept that cycle): `cur_state` ← 0, go to ARMED.
- If `cfg_valid` and `arm` are both high, config wins; `arm` is dropped.

SHIFT:
- For L cycles, `ctl_enable[cfg_state]` = 1 and `ctl_data` = `cfg_word[i]` on the i-th cycle (LSB first).
- `ctl_then` = !cfg_else; `ctl_else` = cfg_else; `ctl_conditions` = !cfg_kind; `ctl_actions` = cfg_kind.
- Then go to GAP.

GAP:
- One cycle, all `ctl_*` = 0, then back to IDLE.

ARMED:
- Each cycle, evaluate k = `cur_state`.
- `disarm` has top priority: go to IDLE, no fire.
- Else, if `st_act[k]`, with A = `st_actions[k]`:
  - A[0] set: `fire` = 1 next cycle, `fire_actions` ← A.
  - A[2] set: `cur_state` ← 0.
  - Else A[1] set: `cur_state` ← k+1; k = `STATE_COUNT-1` wraps to 0.
  - Remaining bits are passed through in `fire_actions` only.
- `arm` in ARMED restarts at stage 0.
- `arm` in SHIFT or GAP is ignored.
- `cfg_valid` in ARMED is held off (`cfg_ready` = 0).

## Timing
- Reset values:
  - `cfg_ready` = 1, FSM = IDLE.
  - `ctl_*` = 0, `cur_state` = 0, `armed` = 0.
  - `fire` = 0, `fire_actions` = 0, `timeout` = 0.
  - Reset mid-SHIFT aborts; the stage holds a partial mask until reloaded.
- All outputs are registered.
- `ctl_*` asserts the cycle after acceptance; a config transaction occupies L+1 cycles after acceptance before `cfg_ready` returns.
- `armed` rises the cycle after `arm`.
- act sampled in cycle n → `fire` and `cur_state` update visible in cycle n+1.
- Stage inputs are sampled every ARMED cycle; consecutive act cycles may advance one stage per cycle.

## Configuration
Macro `OLA_TRIGGER_SEQ_TIMEOUT_EN`.

Defined:
- Counter resets on every stage change and on arm.
- In ARMED with `cur_state` ≠ 0 and no act for `TIMEOUT_CYCLES` consecutive cycles: `cur_state` ← 0 and `timeout` pulses one cycle.
- Act in the expiring cycle wins over timeout.

Undefined:
- No counter logic; `timeout` = 0 constantly.

## Test plan
- Reset, then host writes stage 2, then, conditions, word 0x000A → `ctl_enable` = 0100 for 4 cycles, `ctl_data` = 0,1,0,1, `ctl_conditions` = 1, `ctl_then` = 1, then one gap cycle; `cfg_ready` low for 5 cycles.
- Stage 0 acts with actions 0b0010, stage 1 with 0b0001 → `cur_state` 0→1, then `fire` = 1 for one cycle, `fire_actions` = 0001.
- Stage 3 (last) acts with 0b0010 → `cur_state` wraps to 0; actions 0b0110 → goes to 0 (restart priority).
- `disarm` in the same cycle stage acts with 0b0001 → no fire, `armed` = 0 next cycle; `cfg_valid`+`arm` together in IDLE → config accepted, not armed.
- Assert reset during cycle 2 of SHIFT → all outputs 0 next cycle, `cfg_ready` = 1.
- With macro, `TIMEOUT_CYCLES` = 8, advance to stage 1, hold act low 8 cycles → `timeout` pulse, `cur_state` = 0; without macro, `cur_state` stays 1.
